// File: rtl/imem_pkg.sv
// imem_pkg -- shared types and helpers for the instruction fetch unit.
//   state_e        : fetch FSM states (IDLE, RD_HI, RD_LO, RESP)
//   HW_DEF/AW_DEF/DEPTH_DEF : default halfword width, address width, depth
//   wrap_inc       : (a + 1) mod depth, for the low-half address
//   wrap_mod       : a mod depth, for folding out-of-range request addresses
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_HI = 2'd1,
        RD_LO = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int HW_DEF    = 16;
    localparam int AW_DEF    = 10;
    localparam int DEPTH_DEF = 1024;

    function automatic int wrap_inc(input int a, input int depth);
        return (a + 1 >= depth) ? 0 : a + 1;
    endfunction

    function automatic int wrap_mod(input int a, input int depth);
        return a % depth;
    endfunction

endpackage

// File: rtl/imem_halfword_ram.sv
// imem_halfword_ram -- single-read-port synchronous-read halfword RAM.
//   clk      in  : clock, rising edge
//   rd_en    in  : capture mem[rd_adr] into rd_data at the edge
//   rd_adr   in  : read address (always < DEPTH)
//   rd_data  out : registered read data, held while rd_en is low
//   wr_en    in  : write enable
//   wr_adr   in  : write address; addresses >= DEPTH are dropped
//   wr_data  in  : write halfword
// A read and a write of the same address at one edge return the old
// contents (read-before-write). Contents are not reset.
module imem_halfword_ram
    import imem_pkg::*;
#(
    parameter int HW    = HW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic [HW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [HW-1:0] wr_data
);

    logic [HW-1:0] mem [DEPTH];
    logic [HW-1:0] rd_data_q;
    logic          wr_ok;

    assign wr_ok   = wr_en && (int'(wr_adr) < DEPTH);
    assign rd_data = rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_adr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit -- fetches a 2*HW-bit instruction as two consecutive
// halfwords from a synchronous RAM, with valid/ready on both sides.
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  : fetch request handshake; req_adr = upper-half address
//   rsp_valid/rsp_ready  : response handshake
//   rsp_inst             : {mem[a], mem[(a+1) mod DEPTH]}
//   rsp_err              : a == DEPTH-1 or a >= DEPTH (address wrapped)
//   ld_en/ld_adr/ld_data : program-load write port, blocks new requests
// Optional build macro IMEM_PREFETCH_EN adds a one-entry line buffer that
// answers a repeat fetch of the last completed address in one cycle.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int HW    = HW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_adr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*HW-1:0] rsp_inst,
    output logic            rsp_err,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_adr,
    input  logic [HW-1:0]   ld_data
);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            err_q, err_d;
    logic [HW-1:0]   hi_q, hi_d;
    logic [HW-1:0]   lo_hold_q, lo_hold_d;

    logic            accept;
    logic [AW-1:0]   req_adr_mod;
    logic            req_err;
    logic [AW-1:0]   nxt_adr;
    logic            ram_re;
    logic [AW-1:0]   ram_radr;
    logic [HW-1:0]   rd_data;
    logic [HW-1:0]   lo_out;
    logic            from_ram;
    logic            buf_hit;
    logic [2*HW-1:0] buf_inst;
    logic            buf_err;

    assign req_ready   = (state_q == IDLE) && !ld_en && !rst;
    assign accept      = req_valid && req_ready;
    assign req_adr_mod = AW'(wrap_mod(int'(req_adr), DEPTH));
    // Covers both the last address (a+1 wraps) and out-of-range addresses.
    assign req_err     = int'(req_adr) >= DEPTH - 1;
    assign nxt_adr     = AW'(wrap_inc(int'(addr_q), DEPTH));

    assign ram_re   = (state_q == RD_HI) || (state_q == RD_LO);
    assign ram_radr = (state_q == RD_LO) ? nxt_adr : addr_q;

    imem_halfword_ram #(
        .HW    (HW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_re),
        .rd_adr  (ram_radr),
        .rd_data (rd_data),
        .wr_en   (ld_en),
        .wr_adr  (ld_adr),
        .wr_data (ld_data)
    );

    // The low half of a RAM-path response lives in the RAM output register,
    // which is not read again while in RESP. It is copied to lo_hold_q when
    // the response retires, so rsp_inst stays put until the next RD_LO edge.
    assign lo_out    = (state_q == RESP && from_ram) ? rd_data : lo_hold_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = {hi_q, lo_out};
    assign rsp_err   = rsp_valid && err_q;

`ifdef IMEM_PREFETCH_EN
    logic            tag_valid_q, tag_valid_d;
    logic [AW-1:0]   tag_q, tag_d;
    logic [2*HW-1:0] buf_inst_q, buf_inst_d;
    logic            buf_err_q, buf_err_d;
    logic            from_ram_q, from_ram_d;
    logic            ld_seen_q, ld_seen_d;
    logic [AW-1:0]   tag_nxt;

    assign tag_nxt  = AW'(wrap_inc(int'(tag_q), DEPTH));
    assign buf_hit  = tag_valid_q && (req_adr_mod == tag_q);
    assign buf_inst = buf_inst_q;
    assign buf_err  = buf_err_q;
    assign from_ram = from_ram_q;

    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        buf_inst_d  = buf_inst_q;
        buf_err_d   = buf_err_q;
        from_ram_d  = from_ram_q;
        ld_seen_d   = ld_seen_q;

        if (accept) begin
            from_ram_d = !buf_hit;
            ld_seen_d  = 1'b0;
        end else if (state_q != IDLE && ld_en) begin
            // Data already read may be stale; never cache this fetch.
            ld_seen_d = 1'b1;
        end

        if (state_q == RESP && rsp_ready && from_ram_q && !ld_seen_q && !ld_en) begin
            tag_valid_d = 1'b1;
            tag_d       = addr_q;
            buf_inst_d  = {hi_q, rd_data};
            buf_err_d   = err_q;
        end else if (ld_en && tag_valid_q && (ld_adr == tag_q || ld_adr == tag_nxt)) begin
            tag_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= 1'b0;
            from_ram_q  <= 1'b0;
            ld_seen_q   <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            from_ram_q  <= from_ram_d;
            ld_seen_q   <= ld_seen_d;
        end
        tag_q      <= tag_d;
        buf_inst_q <= buf_inst_d;
        buf_err_q  <= buf_err_d;
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_inst = '0;
    assign buf_err  = 1'b0;
    assign from_ram = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        err_d     = err_q;
        hi_d      = hi_q;
        lo_hold_d = lo_hold_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_adr_mod;
                    if (buf_hit) begin
                        state_d   = RESP;
                        err_d     = buf_err;
                        hi_d      = buf_inst[2*HW-1:HW];
                        lo_hold_d = buf_inst[HW-1:0];
                    end else begin
                        state_d = RD_HI;
                        err_d   = req_err;
                    end
                end
            end
            RD_HI: state_d = RD_LO;
            RD_LO: begin
                // RAM output holds mem[a] here; this edge reads mem[a+1].
                state_d = RESP;
                hi_d    = rd_data;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    lo_hold_d = lo_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            err_q     <= 1'b0;
            hi_q      <= '0;
            lo_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            hi_q      <= hi_d;
            lo_hold_q <= lo_hold_d;
        end
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised successor to the combinational halfword instruction memory.
- Stores HW-bit halfwords in single-read-port synchronous storage and assembles a 2*HW-bit instruction from two consecutive halfwords over a small fetch FSM.
- Adds a valid/ready fetch handshake toward the IF stage and a write port for program loading from the bench or boot logic.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- HW, 16, halfword width in bits; instruction width is 2*HW.
- AW, 10, halfword address width.
- DEPTH, 1024, number of halfwords; must be at most 2**AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted this cycle when high together with req_valid.
- req_adr  in  AW  halfword address of the instruction's upper half.
- rsp_valid  out  1  instruction response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_inst  out  2*HW  {mem[a], mem[a+1]}; upper half comes from the lower address.
- rsp_err  out  1  high with rsp_valid when a+1 wrapped (a == DEPTH-1).
- ld_en  in  1  program-load write enable.
- ld_adr  in  AW  load address.
- ld_data  in  HW  load halfword.

Behaviour:
- Reset: the FSM goes to IDLE; rsp_valid=0, rsp_inst=0, rsp_err=0, latched address=0. Memory contents are not reset.
- Reset mid-fetch aborts the fetch with no response. req_ready stays 0 during the reset cycle.
- States and transitions:
  - IDLE -> RD_HI when req_valid && req_ready.
  - RD_HI -> RD_LO.
  - RD_LO -> RESP.
  - RESP -> IDLE when rsp_ready.
- req_ready = (state==IDLE) && !ld_en. Loads block new fetches but never stall an in-flight fetch.
- Timing, with accept at edge T:
  - edge T latches a = req_adr.
  - edge T+1 captures hi <= mem[a].
  - edge T+2 captures lo <= mem[(a+1) mod DEPTH]; rsp_valid rises after T+2.
  - Best-case throughput is one instruction per 4 cycles.
- rsp_inst and rsp_err hold stable while rsp_valid && !rsp_ready. rsp_valid falls on the edge where rsp_ready is sampled high.
- rsp_inst is unchanged after the response drops, until the next RD_LO capture.
- Wrap-around: addition is modulo DEPTH. a == DEPTH-1 reads mem[0] as the low half and sets rsp_err.
- An address a >= DEPTH (when DEPTH < 2**AW) is reduced modulo DEPTH and sets rsp_err.
- ld_en writes mem[ld_adr] at the edge in any state. Out-of-range ld_adr (>= DEPTH) is ignored.
- Same-cycle load and read of the same address is read-before-write: the fetch returns the old halfword.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- Defined: a one-entry line buffer holds {tag_valid, tag, inst, err} from the last completed response.
  - On a hit (request with req_adr == tag && tag_valid), IDLE -> RESP directly and rsp_valid rises after edge T (latency 1).
  - Invalidation: any ld_en to tag or (tag+1) mod DEPTH clears tag_valid at that edge. A load during an in-flight fetch also suppresses tag installation for that fetch. Reset clears tag_valid.
- Not defined: no buffer; every fetch takes the full RD_HI/RD_LO path. Ports are identical either way.

Decomposition:
- Package imem_pkg:
  - FSM state enum {IDLE, RD_HI, RD_LO, RESP}.
  - Default HW/AW/DEPTH constants.
  - Function for wrapped next-address computation.
- One natural sub-module: imem_halfword_ram, a single-port synchronous-read RAM with write port and read-before-write. It is instantiated once; the FSM and optional buffer stay in the top.

Test Plan:
1. Load mem[0]=16'hC511, mem[1]=16'h01F4; fetch a=0 with rsp_ready=1 -> rsp_valid rises 3 edges after request start (accept+2); rsp_inst=32'hC51101F4, rsp_err=0.
2. Fetch a=5 with rsp_ready=0 for 4 cycles -> rsp_inst held stable and req_ready=0 throughout; it drops one edge after rsp_ready=1, then req_ready=1.
3. Load mem[1023]=16'hAAAA, mem[0]=16'h5555; fetch a=1023 -> rsp_inst=32'hAAAA5555, rsp_err=1.
4. Start fetch a=8 (mem[9]=16'h1111), then drive ld_en to addr 9 with 16'h2222 in the RD_LO cycle -> response low half is 16'h1111. A refetch of a=8 returns low half 16'h2222.
5. Assert rst in the RD_HI cycle -> no rsp_valid; IDLE next cycle; rsp_inst=0.
6. With IMEM_PREFETCH_EN: fetch a=2 twice -> second response latency 1. Then load addr 3 and fetch a=2 -> latency back to full path, with new data.
